// File: rtl/vnm_pkg.sv
// Shared types for the Von Neumann debiaser / word packer.
package vnm_pkg;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_SEL  = 2'd1,
        MODE_RAW  = 2'd2,
        MODE_RSVD = 2'd3
    } vnm_mode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } pair_state_t;

endpackage

// File: rtl/vnm_pair.sv
// Single-bit Von Neumann pair FSM. Emits combinationally on the second bit of an
// unequal pair so the packer can complete a word in the same cycle.
//
// state | meaning
// EMPTY | no bit held; next sample becomes the first bit of a pair
// HELD  | first bit of a pair stored in first_q
module vnm_pair
    import vnm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic en,
    input  logic bit_in,
    input  logic bypass,
    output logic emit,
    output logic bit_out,
    output logic discard
);

    pair_state_t state_q;
    pair_state_t state_cur;
    logic        first_q;

    // A flush in the same cycle as a sample makes that sample the first of a new pair.
    assign state_cur = flush ? EMPTY : state_q;

    // Emit / discard decode from the effective state and the incoming bit.
    always_comb begin
        emit    = 1'b0;
        discard = 1'b0;
        bit_out = bypass ? bit_in : first_q;
        if (en) begin
            if (bypass) begin
                emit = 1'b1;
            end else if (state_cur == HELD) begin
                emit    = (bit_in != first_q);
                discard = (bit_in == first_q);
            end
        end
    end

    // Pair state and stored first bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            first_q <= 1'b0;
        end else if (en) begin
            if (bypass) begin
                state_q <= EMPTY;
            end else if (state_cur == EMPTY) begin
                state_q <= HELD;
                first_q <= bit_in;
            end else begin
                state_q <= EMPTY;
            end
        end else if (flush) begin
            state_q <= EMPTY;
        end
    end

endmodule

// File: rtl/vnm_word_packer.sv
// Multi-channel Von Neumann debiaser and word packer with a one-deep output
// register, sticky overflow and a saturating discarded-pair counter.
module vnm_word_packer
    import vnm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WORD_W   = 8,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] bits_in,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [WORD_W-1:0]   word_data,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overflow,
    output logic [CNT_W-1:0]    discard_cnt
);

    localparam int BC_W = $clog2(WORD_W);

    vnm_mode_t         mode_e;
    logic [1:0]        mode_q;
    logic [SEL_W-1:0]  sel_q;
    logic              src_change;
    logic              flush;
    logic              en;
    logic              src_bit;
    logic              bypass;

    logic              pair_emit;
    logic              pair_bit;
    logic              pair_discard;

    logic [WORD_W-1:0] sr_q, sr_d, sr_base;
    logic [BC_W-1:0]   bc_q, bc_d, bc_base;
    logic [WORD_W-1:0] word_new;
    logic              word_done;

    logic [WORD_W-1:0] data_q;
    logic              valid_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  disc_q;

    assign mode_e     = vnm_mode_t'(mode);
    assign src_change = (mode != mode_q) || (sel != sel_q);
    assign flush      = clr | src_change;
    assign en         = sample_en & ~clr;
    assign bypass     = (mode_e == MODE_RAW);

    // Source bit: selected channel or XOR-fold; out-of-range sel falls back to channel 0.
    always_comb begin
        src_bit = ^bits_in;
        if (mode_e == MODE_SEL) begin
            if (int'(sel) < CHANNELS) begin
                src_bit = bits_in[sel];
            end else begin
                src_bit = bits_in[0];
            end
        end
    end

    vnm_pair u_pair (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .en      (en),
        .bit_in  (src_bit),
        .bypass  (bypass),
        .emit    (pair_emit),
        .bit_out (pair_bit),
        .discard (pair_discard)
    );

    // Right-shifting packer; a source change discards the partial word before this cycle's bit.
    always_comb begin
        sr_base   = flush ? '0 : sr_q;
        bc_base   = flush ? '0 : bc_q;
        sr_d      = sr_base;
        bc_d      = bc_base;
        word_new  = {pair_bit, sr_base[WORD_W-1:1]};
        word_done = 1'b0;
        if (pair_emit) begin
            if (bc_base == BC_W'(WORD_W - 1)) begin
                word_done = 1'b1;
                sr_d      = '0;
                bc_d      = '0;
            end else begin
                sr_d = word_new;
                bc_d = bc_base + BC_W'(1);
            end
        end
    end

    // Source tracking, packer state, output register and health counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= '0;
            sel_q   <= '0;
            sr_q    <= '0;
            bc_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            disc_q  <= '0;
        end else begin
            mode_q <= mode;
            sel_q  <= sel;
            sr_q   <= sr_d;
            bc_q   <= bc_d;
            if (clr) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
                disc_q  <= '0;
            end else begin
                if (word_done) begin
                    if (!valid_q || word_ready) begin
                        data_q  <= word_new;
                        valid_q <= 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end else if (valid_q && word_ready) begin
                    valid_q <= 1'b0;
                end
                if (pair_discard && (disc_q != '1)) begin
                    disc_q <= disc_q + CNT_W'(1);
                end
            end
        end
    end

    assign word_data   = data_q;
    assign word_valid  = valid_q;
    assign overflow    = ovf_q;
    assign discard_cnt = disc_q;

endmodule

// File: tb/tb_vnm_word_packer.sv
// Directed bench for vnm_word_packer (CHANNELS=4, WORD_W=8, CNT_W=16).
module tb_vnm_word_packer;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        sample_en;
    logic [3:0]  bits_in;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        word_ready;
    logic        overflow;
    logic [15:0] discard_cnt;

    int checks;
    int failures;

    vnm_word_packer #(
        .CHANNELS (4),
        .WORD_W   (8),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .sample_en   (sample_en),
        .bits_in     (bits_in),
        .mode        (mode),
        .sel         (sel),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overflow    (overflow),
        .discard_cnt (discard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic samp(input logic [3:0] b);
        bits_in   = b;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    // In MODE_SEL channel 2 carries the bit and the XOR-fold carries its inverse.
    task automatic samp_bit(input logic b);
        if (mode == 2'd1) samp({1'b1, b, 2'b00});
        else              samp({3'b000, b});
    endtask

    task automatic emit_bit(input logic b);
        samp_bit(b);
        samp_bit(~b);
    endtask

    task automatic emit_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) emit_bit(w[i]);
    endtask

    task automatic idle(input int n);
        sample_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || overflow !== 1'b0 || discard_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b disc=%0d, expected 0 0 0 0",
                     word_valid, word_data, overflow, discard_cnt);
        end
    endtask

    task automatic test_reset_midword;
        mode = 2'd0; sel = 2'd0; word_ready = 1'b0;
        emit_word(8'hAA);
        samp_bit(1'b1); samp_bit(1'b1);
        for (int i = 0; i < 5; i++) emit_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || overflow !== 1'b0 || discard_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%h ovf=%b disc=%0d, expected 0 0 0 0",
                     word_valid, word_data, overflow, discard_cnt);
        end
        rst = 1'b0;
        emit_word(8'hAA);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hAA) begin
            failures++;
            $display("FAIL post_reset_word: valid=%b data=%h, expected 1 aa", word_valid, word_data);
        end
    endtask

    task automatic test_sel;
        word_ready = 1'b1;
        mode = 2'd1; sel = 2'd2;
        for (int i = 0; i < 7; i++) emit_bit(i[0]);
        samp_bit(1'b1);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL sel_early: valid=%b after 15 samples, expected 0", word_valid);
        end
        samp_bit(1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hAA || discard_cnt !== 16'd0) begin
            failures++;
            $display("FAIL sel_word: valid=%b data=%h disc=%0d, expected 1 aa 0",
                     word_valid, word_data, discard_cnt);
        end
        idle(1);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL sel_drain: valid=%b, expected 0", word_valid);
        end
    endtask

    task automatic test_xor_discard;
        mode = 2'd0; sel = 2'd0; word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i[0]) begin samp(4'b0111); samp(4'b0111); end
            else      begin samp(4'b0000); samp(4'b0000); end
            if (i == 0) begin
                checks++;
                if (discard_cnt !== 16'd1) begin
                    failures++;
                    $display("FAIL discard_latency: disc=%0d, expected 1", discard_cnt);
                end
            end
            samp(4'b0111); samp(4'b0000);
        end
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hFF || discard_cnt !== 16'd8) begin
            failures++;
            $display("FAIL xor_word: valid=%b data=%h disc=%0d, expected 1 ff 8",
                     word_valid, word_data, discard_cnt);
        end
    endtask

    task automatic test_overflow_clr;
        idle(1);
        word_ready = 1'b0;
        emit_word(8'hFF);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hFF || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first: valid=%b data=%h ovf=%b, expected 1 ff 0", word_valid, word_data, overflow);
        end
        emit_word(8'h00);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hFF || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: valid=%b data=%h ovf=%b, expected 1 ff 1", word_valid, word_data, overflow);
        end
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_single_xfer: valid=%b, expected 0", word_valid);
        end
        clr = 1'b1;
        samp_bit(1'b1);
        clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || discard_cnt !== 16'd0 || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr: ovf=%b disc=%0d valid=%b, expected 0 0 0", overflow, discard_cnt, word_valid);
        end
        emit_word(8'h3C);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h3C || discard_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_priority: valid=%b data=%h disc=%0d, expected 1 3c 0",
                     word_valid, word_data, discard_cnt);
        end
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
    endtask

    task automatic test_raw;
        logic [7:0] raw_bits;
        raw_bits = 8'b1000_1101;
        mode = 2'd2;
        for (int i = 0; i < 7; i++) samp({3'b000, raw_bits[i]});
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_early: valid=%b after 7 samples, expected 0", word_valid);
        end
        samp({3'b000, raw_bits[7]});
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h8D) begin
            failures++;
            $display("FAIL raw_word: valid=%b data=%h, expected 1 8d", word_valid, word_data);
        end
        for (int i = 0; i < 7; i++) samp(4'b0001);
        word_ready = 1'b1;
        samp(4'b0001);
        word_ready = 1'b0;
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hFF || overflow !== 1'b0) begin
            failures++;
            $display("FAIL raw_b2b: valid=%b data=%h ovf=%b, expected 1 ff 0", word_valid, word_data, overflow);
        end
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
    endtask

    task automatic test_mode_change;
        mode = 2'd1; sel = 2'd2; word_ready = 1'b0;
        emit_word(8'hAA);
        samp_bit(1'b1); samp_bit(1'b1);
        emit_bit(1'b0); emit_bit(1'b1); emit_bit(1'b0);
        samp_bit(1'b1);
        mode = 2'd0;
        idle(1);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'hAA || discard_cnt !== 16'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL mode_flush_keep: valid=%b data=%h disc=%0d ovf=%b, expected 1 aa 1 0",
                     word_valid, word_data, discard_cnt, overflow);
        end
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        emit_word(8'h53);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 8'h53 || discard_cnt !== 16'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL mode_new_word: valid=%b data=%h disc=%0d ovf=%b, expected 1 53 1 0",
                     word_valid, word_data, discard_cnt, overflow);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; clr = 1'b0; sample_en = 1'b0; bits_in = 4'h0;
        mode = 2'd0; sel = 2'd0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        idle(1);
        test_reset_midword;
        test_sel;
        test_xor_discard;
        test_overflow_clr;
        test_raw;
        test_mode_change;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vnm_word_packer.md
# vnm_word_packer

Multi-channel Von Neumann debiaser and word packer for the ring-oscillator entropy path. It samples `CHANNELS` raw oscillator bits and conditions them with non-overlapping-pair Von Neumann correction. Corrected bits are packed into `WORD_W`-bit words and handed downstream on a valid/ready handshake. It sits between the `inv_clk`/`flip_flop` sampling stage and the RNG output register, and reports dropped words and discarded pairs for health monitoring.

## Interface
Parameters:
- `CHANNELS`, 4: number of raw entropy inputs; must be ≥ 1.
- `WORD_W`, 8: output word width; must be ≥ 2.
- `CNT_W`, 16: width of the saturating discard counter.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush of all state; same targets as `rst`.
- `sample_en`  in  1  `bits_in` is valid this cycle.
- `bits_in`  in  CHANNELS  raw sampled oscillator bits.
- `mode`  in  2  source mode; see Operation.
- `sel`  in  $clog2(CHANNELS) (min 1)  channel index for `MODE_SEL`.
- `word_data`  out  WORD_W  packed output word.
- `word_valid`  out  1  `word_data` is held and valid.
- `word_ready`  in  1  downstream accepts the word.
- `overflow`  out  1  sticky flag: a completed word was dropped.
- `discard_cnt`  out  CNT_W  count of equal pairs discarded; saturates.

## Operation
- **Source bit per sample:**
  - `MODE_XOR` (0): XOR of all `bits_in`.
  - `MODE_SEL` (1): `bits_in[sel]`. If `sel` ≥ CHANNELS, use channel 0.
  - `MODE_RAW` (2): XOR-fold, with Von Neumann correction bypassed.
  - `MODE_RSVD` (3): behaves as `MODE_XOR`.
- **Pair FSM**, states `EMPTY` and `HELD`. It advances only on `sample_en`.
  - `EMPTY` → `HELD`: store the source bit as `first`.
  - `HELD` → `EMPTY`, bits unequal: emit `first` (pair 10 → 1, pair 01 → 0).
  - `HELD` → `EMPTY`, bits equal: no emit; `discard_cnt` += 1, saturating at all-ones.
  - In `MODE_RAW`, every sample emits directly and the FSM stays `EMPTY`.
- **Packer:**
  - Each emitted bit shifts into the MSB of the `WORD_W` shift register (shift right), so the first bit emitted ends in `word_data[0]`.
  - A bit counter tracks the number of bits held.
  - When the emitted bit is the `WORD_W`-th, the full word goes to the output register and the counter wraps to 0.
- **Output register (one deep):**
  - If the register is empty, or it is being accepted this cycle (`word_valid & word_ready`), the new word loads and `word_valid` = 1.
  - If the register is full and not accepted, the new word is dropped, `overflow` is set, and the held `word_data` is unchanged.
- **Handshake:**
  - Transfer occurs on a cycle with `word_valid & word_ready`.
  - Without a new word, `word_valid` falls next cycle.
  - `word_data` is stable while `word_valid & ~word_ready`.
- **Mode/sel change:** `mode` and `sel` are registered internally. Any change relative to the registered copy forces the pair FSM to `EMPTY` and clears the partial word, so bits from the old source never mix with the new one. The output register, `overflow` and `discard_cnt` are kept.
- **`clr`:** clears everything, including `overflow` and `discard_cnt`, and has priority over `sample_en` in the same cycle.
- **`rst`:** clears everything immediately, including mid-pair and mid-word.

## Timing
- Reset values: `word_data` = 0, `word_valid` = 0, `overflow` = 0, `discard_cnt` = 0, FSM `EMPTY`, bit counter 0.
- Latency:
  - The last sample completing a word, at cycle t, gives `word_valid` = 1 in cycle t+1.
  - A discard at cycle t shows in `discard_cnt` at t+1.
- Best-case throughput:
  - VN modes: one word per 2·`WORD_W` sampled cycles.
  - `MODE_RAW`: one word per `WORD_W` sampled cycles.
- Simultaneous events:
  - Word completion plus a handshake in the same cycle: the new word loads, `word_valid` stays 1, no overflow.
  - Mode change plus `sample_en` in the same cycle: flush first, then the sample is processed as the first bit under the new mode.
- `word_ready` has no combinational path to any output.

## Structure
- Package `vnm_pkg`:
  - `typedef enum logic [1:0] {MODE_XOR, MODE_SEL, MODE_RAW, MODE_RSVD} vnm_mode_t`.
  - `typedef enum logic {EMPTY, HELD} pair_state_t`.
- Sub-module `vnm_pair`: single-bit pair FSM. Inputs `clk`, `rst`, `flush`, `en`, `bit_in`, `bypass`; outputs `emit`, `bit_out`, `discard`.
- The top level holds the source mux, change detector, packer, output register and counters.

## Test plan
All scenarios use CHANNELS=4, WORD_W=8.
1. Assert `rst` mid-word (after 5 emitted bits) → all outputs 0 immediately. The next 16 samples (pairs 01,10 ×4) give `word_data` = 8'hAA, with no remnant bits.
2. `MODE_SEL`, `sel`=2, channel 2 driven with pairs 01,10 repeated (16 samples), `word_ready`=1 → `word_valid` one cycle after the 16th sample, `word_data` = 8'hAA, `discard_cnt` = 0.
3. `MODE_XOR`, `bits_in` alternating 4'b0111 then 4'b0000 for 16 samples, with 8 pairs 00 and 11 interleaved → `word_data` = 8'hFF, `discard_cnt` = 8.
4. `word_ready`=0 while producing two words → first word held with `word_valid`=1, second dropped, `overflow`=1. Raising `word_ready` gives one transfer, then `word_valid`=0. `clr` gives `overflow`=0.
5. `MODE_RAW`, 8 samples with XOR-fold 1,0,1,1,0,0,0,1 → `word_data` = 8'h8D after 8 samples. `word_ready`=1 on the cycle the next word completes → `word_valid` stays high, the new word loads, no overflow.
6. Switch `mode` 1→0 while in `HELD` with 3 bits packed → flush. The next 16 samples alone form the word; the held word and `discard_cnt` are unchanged.
